data_memory_unit: RTL

//  Responder for the core's data-memory port (memRead/memWrite/memAddr/memDataIn -> memDataOut).

---
 rtl/data_memory_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/data_memory_unit.sv
// Data-memory responder: word-addressed RAM plus a small MMIO window (GPIO, cycle
// counter, W1C error status, store counter). Load data is combinational.
module data_memory_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int unsigned GPIO_W      = 8
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [31:0]       memAddr,
  input  logic [31:0]       memDataIn,
  output logic [31:0]       memDataOut,
  output logic [GPIO_W-1:0] gpioOut,
  output logic [1:0]        errStatus
);

  localparam logic [1:0] REG_GPIO   = 2'd0;
  localparam logic [1:0] REG_CYCLE  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_STORES = 2'd3;

  logic [31:0]       ram_r [DEPTH_WORDS];
  logic [31:0]       cycleCnt_r;
  logic [31:0]       storeCnt_r;
  logic [GPIO_W-1:0] gpio_r;
  logic [1:0]        err_r;

  logic              req_s;
  logic              misaligned_s;
  logic              ramHit_s;
  logic              mmioHit_s;
  logic              unmapped_s;
  logic              access_s;
  logic              write_s;
  logic [1:0]        regSel_s;
  logic [ADDR_W-1:0] ramIdx_s;
  logic              ramWe_s;
  logic              gpioWe_s;
  logic              statusWe_s;
  logic              storeInc_s;
  logic [1:0]        errSet_s;
  logic [1:0]        errClr_s;

  // Address decode and per-target write strobes.
  always_comb begin
    req_s        = memRead | memWrite;
    misaligned_s = (memAddr[1:0] != 2'b00);
    ramHit_s     = (memAddr[31:ADDR_W+2] == {(32-ADDR_W-2){1'b0}});
    mmioHit_s    = (memAddr[31:4] == MMIO_BASE[31:4]);
    unmapped_s   = !ramHit_s && !mmioHit_s;
    access_s     = !misaligned_s && !unmapped_s;
    write_s      = memWrite && access_s;
    regSel_s     = memAddr[3:2];
    ramIdx_s     = memAddr[ADDR_W+1:2];
    ramWe_s      = write_s && ramHit_s;
    gpioWe_s     = write_s && mmioHit_s && (regSel_s == REG_GPIO);
    statusWe_s   = write_s && mmioHit_s && (regSel_s == REG_STATUS);
    storeInc_s   = ramWe_s || gpioWe_s;
    errSet_s     = {req_s && unmapped_s, req_s && misaligned_s};
    if (statusWe_s) begin
      errClr_s = memDataIn[1:0];
    end else begin
      errClr_s = 2'b00;
    end
  end

  // Zero-latency read mux; suppressed or idle accesses return zero.
  always_comb begin
    memDataOut = 32'h0000_0000;
    if (memRead && access_s) begin
      if (ramHit_s) begin
        memDataOut = ram_r[ramIdx_s];
      end else begin
        case (regSel_s)
          REG_GPIO:   memDataOut = {{(32-GPIO_W){1'b0}}, gpio_r};
          REG_CYCLE:  memDataOut = cycleCnt_r;
          REG_STATUS: memDataOut = {30'd0, err_r};
          REG_STORES: memDataOut = storeCnt_r;
          default:    memDataOut = 32'h0000_0000;
        endcase
      end
    end else begin
      memDataOut = 32'h0000_0000;
    end
  end

  // RAM array; a write coinciding with reset is dropped.
  always_ff @(posedge CLK) begin
    if (ramWe_s && RES) begin
      ram_r[ramIdx_s] <= memDataIn;
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      cycleCnt_r <= 32'h0000_0000;
    end else begin
      cycleCnt_r <= cycleCnt_r + 32'd1;
    end
  end

  // GPIO register and accepted-store counter.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      gpio_r     <= {GPIO_W{1'b0}};
      storeCnt_r <= 32'h0000_0000;
    end else begin
      if (gpioWe_s) begin
        gpio_r <= memDataIn[GPIO_W-1:0];
      end
      if (storeInc_s) begin
        storeCnt_r <= storeCnt_r + 32'd1;
      end
    end
  end

  // Sticky error bits: a new error in the same cycle beats the W1C clear.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      err_r <= 2'b00;
    end else begin
      err_r <= (err_r & ~errClr_s) | errSet_s;
    end
  end

  assign gpioOut   = gpio_r;
  assign errStatus = err_r;

endmodule
